cgra_out_fifo: RTL and testbench
================================

Name: cgra_out_fifo

Overview:
- Output-side elastic buffer directly downstream of the CGRA UUT interface.
- Accepts the write stream (req_wr_data/wr_data) and presents a registered valid/ready stream to the shell output.
- Drives the producer's available_write through an almost-full margin so that words still in flight in the producer pipeline are never lost.
- Reports occupancy and a sticky overflow flag.

Parameters:
DATA_W, 512, data word width
DEPTH, 8, array entries; power of two, >= 2; total capacity DEPTH+1 (array + output register)
AF_MARGIN, 2, free slots that must remain for enable_out to stay high; range 0..DEPTH
CNT_W, $clog2(DEPTH+2), derived localparam; occupancy width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
valid_in  in  1  write strobe from producer (req_wr_data)
din  in  DATA_W  write data (wr_data)
enable_out  out  1  space available; connects to producer available_write
valid_out  out  1  dout holds a valid word
ready_out  in  1  downstream accepts the word this cycle
dout  out  DATA_W  registered head word
count  out  CNT_W  words held (array + output register), 0..DEPTH+1
overflow  out  1  sticky: write was dropped because the buffer was full

Behaviour:
- Reset (rst=0, async):
  - Pointers, count, valid_out, overflow and dout clear to 0.
  - enable_out=1, since it derives from count=0 and AF_MARGIN <= DEPTH.
  - Reset mid-stream discards all contents; no partial words.
- Storage:
  - Circular array of DEPTH entries; wr_ptr/rd_ptr wrap modulo DEPTH.
  - A separate output register drives dout and valid_out. No combinational path from din to dout.
- Pop: transfer occurs when valid_out && ready_out. Next cycle the output register loads the array head if one exists; otherwise valid_out drops to 0.
- Push: accepted when valid_in && count < DEPTH+1, using the registered count.
  - If the output register is empty, or is being popped this cycle while the array is empty, din loads straight into the output register (bypass).
  - Otherwise din is written to the array at wr_ptr.
- Latency: from an empty buffer, a word pushed in cycle N appears with valid_out=1 in cycle N+1.
- Full (count == DEPTH+1) with valid_in=1:
  - The word is dropped and overflow sets, remaining set until reset.
  - This holds even if a pop occurs the same cycle; full is judged on the registered count.
- Simultaneous push and pop when not full: count unchanged, ordering preserved.
- Empty with ready_out=1: no effect; valid_out stays 0 and dout holds its last value.
- count: +1 on push, -1 on pop, unchanged when both or neither occur.
- enable_out: combinational from the registered count; enable_out = ((DEPTH+1 - count) > AF_MARGIN).
- ordering: strict FIFO; no reordering, no duplication.
- Outputs are stable while valid_out=1 && ready_out=0; dout must not change while stalled.

Optional Feature:
- Macro: CGRA_OUT_FIFO_STATS_EN.
- Defined: adds two output ports.
  - words_out [31:0]: counts completed pops.
  - stall_cycles [31:0]: counts cycles with valid_out && !ready_out.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports and their counters are absent. Core behaviour is identical.

Test Plan:
- Single word: after reset, din=0xA5 (zero-extended), valid_in=1 for one cycle, ready_out=1 -> valid_out=1 with dout=0xA5 next cycle; count returns 0 the cycle after.
- Fill: ready_out=0, push 9 words 1..9 (DEPTH=8, AF_MARGIN=2) -> enable_out falls once count reaches 7; count=9; overflow=0.
- Overflow: continue from fill, push 0x10 with ready_out=1 the same cycle -> word dropped, overflow=1 sticky; drain yields exactly 1..9 in order.
- Streaming: valid_in=1 and ready_out=1 continuously for 20 words -> dout sequence equals input sequence, count constant at 1, no bubbles after the first word.
- Backpressure stall: valid_out=1 with ready_out=0 for 5 cycles -> dout unchanged; with STATS_EN, stall_cycles=5.
- Async reset mid-operation: rst=0 pulsed between clock edges with count=4 -> valid_out, count and overflow go to 0 immediately; enable_out=1; post-reset push behaves as in the single-word test.

Source files
------------

// File: rtl/cgra_out_fifo.sv
// cgra_out_fifo: output elastic buffer behind the CGRA UUT write port.
// Optional stats counters: define CGRA_OUT_FIFO_STATS_EN.
module cgra_out_fifo #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  localparam int CNT_W    = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] din,
  output logic              enable_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
`ifdef CGRA_OUT_FIFO_STATS_EN
  output logic [31:0]       words_out,
  output logic [31:0]       stall_cycles,
`endif
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C =
    CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] AF_C =
    CNT_W'(AF_MARGIN);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_vout;
  logic [DATA_W-1:0] r_dout;
  logic              r_ovf;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W-1:0]  w_arr_cnt;
  logic              w_arr_empty;
  logic              w_bypass;
  logic              w_wr_arr;
  logic              w_rd_arr;
  logic [CNT_W-1:0]  w_free;

  // Transfer decisions, all judged on registered state.
  always_comb begin
    w_full      = (r_count == FULL_C);
    w_pop       = r_vout & ready_out;
    w_push      = valid_in & ~w_full;
    w_arr_cnt   = r_count - CNT_W'(r_vout);
    w_arr_empty = (w_arr_cnt == '0);
    w_bypass    = ~r_vout | (w_pop & w_arr_empty);
    w_wr_arr    = w_push & ~w_bypass;
    w_rd_arr    = w_pop & ~w_arr_empty;
    w_free      = FULL_C - r_count;
  end

  // Array storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_arr)
      r_mem[r_wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_arr)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_arr)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CNT_W'(1);
      if (valid_in && w_full)
        r_ovf <= 1'b1;
    end
  end

  // Output register: refill from array head, else bypass din.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vout <= 1'b0;
      r_dout <= '0;
    end else if (w_rd_arr) begin
      r_vout <= 1'b1;
      r_dout <= r_mem[r_rd_ptr];
    end else if (w_push && w_bypass) begin
      r_vout <= 1'b1;
      r_dout <= din;
    end else if (w_pop) begin
      r_vout <= 1'b0;
    end
  end

`ifdef CGRA_OUT_FIFO_STATS_EN
  logic [31:0] r_words;
  logic [31:0] r_stall;

  // Saturating pop and stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_words <= '0;
      r_stall <= '0;
    end else begin
      if (w_pop && r_words != 32'hFFFF_FFFF)
        r_words <= r_words + 32'd1;
      if (r_vout && !ready_out &&
          r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
    end
  end

  assign words_out    = r_words;
  assign stall_cycles = r_stall;
`endif

  assign enable_out = (w_free > AF_C);
  assign valid_out  = r_vout;
  assign dout       = r_dout;
  assign count      = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_cgra_out_fifo.sv
// tb_cgra_out_fifo: directed self-checking bench.
// Default parameters: DATA_W=512, DEPTH=8, AF_MARGIN=2.
module tb_cgra_out_fifo;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [511:0] din;
  logic         enable_out;
  logic         valid_out;
  logic         ready_out;
  logic [511:0] dout;
  logic [3:0]   count;
  logic         overflow;
`ifdef CGRA_OUT_FIFO_STATS_EN
  logic [31:0]  words_out;
  logic [31:0]  stall_cycles;
`endif

  int checks;
  int errors;

  cgra_out_fifo u_dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .din          (din),
    .enable_out   (enable_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .dout         (dout),
    .count        (count),
`ifdef CGRA_OUT_FIFO_STATS_EN
    .words_out    (words_out),
    .stall_cycles (stall_cycles),
`endif
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [511:0] got,
    input logic [511:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vout"}, 512'(valid_out), 512'd0);
    chk({tag, "_cnt"},  512'(count),     512'd0);
    chk({tag, "_ovf"},  512'(overflow),  512'd0);
    chk({tag, "_en"},   512'(enable_out), 512'd1);
  endtask

  task automatic single_word(input string tag);
    din       = 512'hA5;
    valid_in  = 1'b1;
    ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_vout"}, 512'(valid_out), 512'd1);
    chk({tag, "_dout"}, dout, 512'hA5);
    chk({tag, "_cnt1"}, 512'(count), 512'd1);
    tick();
    chk({tag, "_cnt0"}, 512'(count), 512'd0);
    chk({tag, "_vout0"}, 512'(valid_out), 512'd0);
    chk({tag, "_hold"}, dout, 512'hA5);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    din       = '0;
    #12;
    chk_idle("rst");
    chk("rst_dout", dout, 512'd0);
    rst = 1'b1;
    tick();

    single_word("single");

    // empty with ready: nothing happens
    tick();
    chk("empty_vout", 512'(valid_out), 512'd0);
    chk("empty_dout", dout, 512'hA5);

    // fill 9 words, no draining
    ready_out = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      din      = 512'(i);
      valid_in = 1'b1;
      tick();
      chk($sformatf("fill_cnt%0d", i),
          512'(count), 512'(i));
      chk($sformatf("fill_en%0d", i),
          512'(enable_out), 512'(i < 7));
    end
    chk("fill_ovf", 512'(overflow), 512'd0);
    chk("fill_head", dout, 512'd1);

    // full: push with pop same cycle is dropped
    din       = 512'h10;
    valid_in  = 1'b1;
    ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("ovf_set", 512'(overflow), 512'd1);
    chk("ovf_cnt", 512'(count), 512'd8);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("drain_v%0d", k),
          512'(valid_out), 512'd1);
      chk($sformatf("drain_d%0d", k),
          dout, 512'(k));
      tick();
    end
    chk("drain_vout", 512'(valid_out), 512'd0);
    chk("drain_cnt", 512'(count), 512'd0);
    chk("ovf_sticky", 512'(overflow), 512'd1);

    // streaming 20 words
    valid_in  = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 512'(16'h100 + i);
      tick();
      chk($sformatf("strm_v%0d", i),
          512'(valid_out), 512'd1);
      chk($sformatf("strm_d%0d", i),
          dout, 512'(16'h100 + i));
      chk($sformatf("strm_c%0d", i),
          512'(count), 512'd1);
    end
    valid_in = 1'b0;
    tick();
    chk("strm_end", 512'(count), 512'd0);

    // backpressure stall after a fresh reset
    do_reset();
    chk("rst2_ovf", 512'(overflow), 512'd0);
    din       = 512'hBEEF;
    valid_in  = 1'b1;
    ready_out = 1'b0;
    tick();
    valid_in = 1'b0;
    din      = 512'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_d%0d", i),
          dout, 512'hBEEF);
      chk($sformatf("stall_v%0d", i),
          512'(valid_out), 512'd1);
    end
`ifdef CGRA_OUT_FIFO_STATS_EN
    chk("stall_cnt", 512'(stall_cycles), 512'd5);
    chk("words0", 512'(words_out), 512'd0);
`endif
    ready_out = 1'b1;
    tick();
    chk("stall_pop", 512'(valid_out), 512'd0);
`ifdef CGRA_OUT_FIFO_STATS_EN
    chk("words1", 512'(words_out), 512'd1);
    chk("stall_hold", 512'(stall_cycles), 512'd5);
`endif

    // async reset mid-stream with count=4
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 512'(8'h40 + i);
      tick();
    end
    valid_in = 1'b0;
    chk("mid_cnt4", 512'(count), 512'd4);
    chk("mid_en", 512'(enable_out), 512'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_dout", dout, 512'd0);
    #1;
    rst = 1'b1;
    tick();
    chk_idle("post");
    single_word("post_single");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
